ring_ctr_checker: RTL and testbench

- Receive-side monitor for the one-hot ring counter (ring_ctr) output bus.
- Samples the ring bus each enabled cycle and decodes the hot bit to a binary position.
- Checks the hot bit advances by exactly one place per sample in the configured direction.
- Locks onto a valid sequence and flags and counts sequence errors; sits beside ring_ctr in benches and in-system as a health checker.

---
 rtl/ring_ctr_checker_if.sv | 34 +++
 rtl/ring_ctr_checker.sv | 200 ++++++++++++++++++++
 tb/tb_ring_ctr_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_ctr_checker_if.sv
// ring_ctr_checker_if: bundles the checker's sampled inputs and its status outputs.
//   en        : sample enable (driven by master)
//   ring_in   : ring counter bus under test (driven by master)
//   err_clr   : synchronous clear of the error counter (driven by master)
//   pos       : binary index of the hot bit in the last valid sample
//   pos_valid : last sample was exactly one-hot
//   locked    : sequence tracking established
//   err       : one-cycle pulse on a sequence error while locked
//   err_cnt   : saturating error count
interface ring_ctr_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    localparam int POS_W = $clog2(WIDTH);

    logic                 en;
    logic [WIDTH-1:0]     ring_in;
    logic                 err_clr;
    logic [POS_W-1:0]     pos;
    logic                 pos_valid;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output en, ring_in, err_clr,
        input  pos, pos_valid, locked, err, err_cnt
    );

    modport slave (
        input  en, ring_in, err_clr,
        output pos, pos_valid, locked, err, err_cnt
    );
endinterface

// File: rtl/ring_ctr_checker.sv
// ring_ctr_checker: receive-side health monitor for a one-hot ring counter bus.
// Decodes the hot bit, tracks that it advances one place per enabled sample in
// the DIR direction, locks after LOCK_CNT consecutive correct steps and, once
// locked, pulses err and counts every sequence break.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of ring_ctr_checker_if (en, ring_in, err_clr in;
//          pos, pos_valid, locked, err, err_cnt out, all registered)
module ring_ctr_checker #(
    parameter int WIDTH     = 4,
    parameter int DIR       = 0,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    ring_ctr_checker_if.slave  bus
);

    localparam int POS_W = $clog2(WIDTH);
    localparam int MCW   = $clog2(LOCK_CNT + 1);
    localparam logic [MCW-1:0]       LOCK_VAL = MCW'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] low_s;
        low_s = v - {{(WIDTH-1){1'b0}}, 1'b1};
        return (v != {WIDTH{1'b0}}) && ((v & low_s) == {WIDTH{1'b0}});
    endfunction

    // Binary index of the set bit; only meaningful for one-hot input.
    function automatic logic [POS_W-1:0] hot_index(input logic [WIDTH-1:0] v);
        logic [POS_W-1:0] idx;
        idx = {POS_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = POS_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [WIDTH-1:0]     prev_r, prev_nxt_s;
    logic [WIDTH-1:0]     exp_s;
    logic [MCW-1:0]       match_cnt_r, match_nxt_s, match_inc_s;
    logic                 onehot_s;
    logic                 new_err_s;

    logic [POS_W-1:0]     pos_r, pos_nxt_s;
    logic                 pos_valid_r, pos_valid_nxt_s;
    logic                 locked_r, locked_nxt_s;
    logic                 err_r, err_nxt_s;
    logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;

    assign onehot_s    = is_onehot(bus.ring_in);
    assign match_inc_s = match_cnt_r + MCW'(1'b1);

    // Expected next sample: previous accepted value rotated one place; the
    // end-around wrap is just part of the rotation.
    generate
        if (DIR == 0) begin : g_right
            assign exp_s = {prev_r[0], prev_r[WIDTH-1:1]};
        end else begin : g_left
            assign exp_s = {prev_r[WIDTH-2:0], prev_r[WIDTH-1]};
        end
    endgenerate

    // State register plus tracking datapath (last accepted sample, step count).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_UNLOCKED;
            prev_r      <= {WIDTH{1'b0}};
            match_cnt_r <= {MCW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            prev_r      <= prev_nxt_s;
            match_cnt_r <= match_nxt_s;
        end
    end

    // Next-state logic; nothing advances while en is low.
    always_comb begin
        state_nxt_s = state_r;
        prev_nxt_s  = prev_r;
        match_nxt_s = match_cnt_r;
        new_err_s   = 1'b0;
        if (bus.en) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (onehot_s) begin
                        prev_nxt_s  = bus.ring_in;
                        match_nxt_s = {MCW{1'b0}};
                        state_nxt_s = ST_ACQUIRE;
                    end else begin
                        state_nxt_s = ST_UNLOCKED;
                    end
                end
                ST_ACQUIRE: begin
                    // prev is one-hot here, so a match implies ring_in is one-hot
                    if (bus.ring_in == exp_s) begin
                        prev_nxt_s  = bus.ring_in;
                        match_nxt_s = match_inc_s;
                        if (match_inc_s == LOCK_VAL) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_ACQUIRE;
                        end
                    end else if (onehot_s) begin
                        // wrong step: reseed from this sample, no error while acquiring
                        prev_nxt_s  = bus.ring_in;
                        match_nxt_s = {MCW{1'b0}};
                        state_nxt_s = ST_ACQUIRE;
                    end else begin
                        state_nxt_s = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (bus.ring_in == exp_s) begin
                        prev_nxt_s  = bus.ring_in;
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        // failing sample is dropped; reacquire from the next one
                        new_err_s   = 1'b1;
                        state_nxt_s = ST_UNLOCKED;
                    end
                end
                default: begin
                    state_nxt_s = ST_UNLOCKED;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        pos_nxt_s       = pos_r;
        pos_valid_nxt_s = pos_valid_r;
        locked_nxt_s    = locked_r;
        err_nxt_s       = 1'b0;
        err_cnt_nxt_s   = err_cnt_r;
        if (bus.en) begin
            if (onehot_s) begin
                pos_nxt_s       = hot_index(bus.ring_in);
                pos_valid_nxt_s = 1'b1;
            end else begin
                pos_valid_nxt_s = 1'b0;
            end
            locked_nxt_s = (state_nxt_s == ST_LOCKED);
            err_nxt_s    = new_err_s;
            // a clear coinciding with a new error leaves that error counted
            if (bus.err_clr) begin
                err_cnt_nxt_s = new_err_s ? {{(ERR_CNT_W-1){1'b0}}, 1'b1}
                                          : {ERR_CNT_W{1'b0}};
            end else if (new_err_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_nxt_s = err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos_r       <= {POS_W{1'b0}};
            pos_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= {ERR_CNT_W{1'b0}};
        end else begin
            pos_r       <= pos_nxt_s;
            pos_valid_r <= pos_valid_nxt_s;
            locked_r    <= locked_nxt_s;
            err_r       <= err_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
        end
    end

    assign bus.pos       = pos_r;
    assign bus.pos_valid = pos_valid_r;
    assign bus.locked    = locked_r;
    assign bus.err       = err_r;
    assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ring_ctr_checker.sv
// Bench for ring_ctr_checker: a DIR=0 and a DIR=1 instance (WIDTH=4, LOCK_CNT=2,
// ERR_CNT_W=8) checked every cycle against a position-arithmetic reference model.
module tb_ring_ctr_checker;

    localparam int W    = 4;
    localparam int LOCK = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ring_ctr_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) if0 ();
    ring_ctr_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) if1 ();

    ring_ctr_checker #(.WIDTH(W), .DIR(0), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rstn(rstn), .bus(if0.slave));
    ring_ctr_checker #(.WIDTH(W), .DIR(1), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut1 (
        .clk(clk), .rstn(rstn), .bus(if1.slave));

    int n_vec = 0;
    int n_err = 0;

    // Reference model per instance: hot position arithmetic, index d = DIR.
    int m_pos[2], m_valid[2], m_locked[2], m_err[2], m_cnt[2];
    int m_seeded[2], m_last[2], m_run[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0; m_valid[d] = 0; m_locked[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
            m_seeded[d] = 0; m_last[d] = 0; m_run[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, input logic e, input logic c);
        int  p, nxt;
        bit  oh;
        m_err[d] = 0;
        if (!e) return;
        oh  = ($countones(r) == 1);
        p   = oh ? $clog2(r) : -1;
        nxt = (d == 0) ? (m_last[d] + W - 1) % W : (m_last[d] + 1) % W;
        if (oh) begin m_pos[d] = p; m_valid[d] = 1; end
        else m_valid[d] = 0;
        if (m_locked[d] != 0) begin
            if (oh && p == nxt) m_last[d] = p;
            else begin m_err[d] = 1; m_locked[d] = 0; m_seeded[d] = 0; end
        end else if (m_seeded[d] != 0) begin
            if (oh && p == nxt) begin
                m_last[d] = p; m_run[d]++;
                if (m_run[d] == LOCK) m_locked[d] = 1;
            end else if (oh) begin
                m_last[d] = p; m_run[d] = 0;
            end else m_seeded[d] = 0;
        end else if (oh) begin
            m_seeded[d] = 1; m_last[d] = p; m_run[d] = 0;
        end
        if (c) m_cnt[d] = m_err[d];
        else if (m_err[d] != 0 && m_cnt[d] < 255) m_cnt[d]++;
    endtask

    task automatic chk(input string tag, input int d, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d t=%0t observed=%0d expected=%0d", tag, d, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos"},       0, int'(if0.pos),       m_pos[0]);
        chk({tag, ".pos_valid"}, 0, int'(if0.pos_valid), m_valid[0]);
        chk({tag, ".locked"},    0, int'(if0.locked),    m_locked[0]);
        chk({tag, ".err"},       0, int'(if0.err),       m_err[0]);
        chk({tag, ".err_cnt"},   0, int'(if0.err_cnt),   m_cnt[0]);
        chk({tag, ".pos"},       1, int'(if1.pos),       m_pos[1]);
        chk({tag, ".pos_valid"}, 1, int'(if1.pos_valid), m_valid[1]);
        chk({tag, ".locked"},    1, int'(if1.locked),    m_locked[1]);
        chk({tag, ".err"},       1, int'(if1.err),       m_err[1]);
        chk({tag, ".err_cnt"},   1, int'(if1.err_cnt),   m_cnt[1]);
    endtask

    // Apply inputs (just after an active edge), clock once, update model, check.
    task automatic drive(input string tag, input logic [3:0] r0, input logic [3:0] r1,
                         input logic e, input logic c);
        if0.ring_in = r0; if0.en = e; if0.err_clr = c;
        if1.ring_in = r1; if1.en = e; if1.err_clr = c;
        @(posedge clk);
        if (!rstn) model_reset();
        else begin
            model_step(0, r0, e, c);
            model_step(1, r1, e, c);
        end
        #1;
        check_all(tag);
    endtask

    task automatic both(input string tag, input logic [3:0] r);
        drive(tag, r, r, 1'b1, 1'b0);
    endtask

    initial begin
        int cp0, cp1;
        logic [3:0] r0, r1;
        logic e, c;

        model_reset();
        rstn = 1'b0;
        if0.ring_in = 4'b0100; if0.en = 1'b1; if0.err_clr = 1'b0;
        if1.ring_in = 4'b0100; if1.en = 1'b1; if1.err_clr = 1'b0;

        // Reset held with a valid sample present: everything stays 0.
        for (int i = 0; i < 3; i++) both("rst_hold", 4'b0100);
        chk("rst_locked", 0, int'(if0.locked), 0);
        rstn = 1'b1;

        // Clean right-rotating sequence, including the bit0 -> bit3 wrap.
        both("clean", 4'b0001);
        both("clean", 4'b1000);
        both("clean", 4'b0100);
        chk("lock_3rd", 0, int'(if0.locked), 1);
        both("clean", 4'b0010);
        both("clean", 4'b0001);
        both("clean", 4'b1000);
        chk("wrap_pos", 0, int'(if0.pos), 3);

        // Stalled counter while locked, then reacquire.
        both("stall", 4'b0100);
        both("stall", 4'b0010);
        both("stall", 4'b0010);
        chk("stall_err", 0, int'(if0.err), 1);
        both("stall", 4'b0001);
        chk("stall_pulse", 0, int'(if0.err), 0);
        both("stall", 4'b1000);
        both("stall", 4'b0100);
        chk("relock", 0, int'(if0.locked), 1);

        // Multi-hot then all-zero while locked.
        both("inval", 4'b0010);
        both("inval", 4'b0110);
        chk("inval_pos", 0, int'(if0.pos), 1);
        both("inval", 4'b0000);

        // Lock, then a five-cycle enable gap with garbage on the bus.
        both("gap", 4'b0001);
        both("gap", 4'b1000);
        both("gap", 4'b0100);
        for (int i = 0; i < 5; i++) drive("gap_off", 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        both("gap", 4'b0010);
        chk("gap_locked", 0, int'(if0.locked), 1);

        // Left rotation on the DIR=1 instance.
        drive("left", 4'b0001, 4'b0001, 1'b1, 1'b0);
        drive("left", 4'b1000, 4'b0010, 1'b1, 1'b0);
        drive("left", 4'b0100, 4'b0100, 1'b1, 1'b0);
        chk("left_lock", 1, int'(if1.locked), 1);

        // Asynchronous reset mid-cycle while locked.
        #2 rstn = 1'b0;
        #1;
        chk("async_locked", 0, int'(if0.locked), 0);
        chk("async_pos", 0, int'(if0.pos), 0);
        chk("async_cnt", 0, int'(if0.err_cnt), 0);
        model_reset();
        both("async_hold", 4'b0010);
        rstn = 1'b1;
        both("seed", 4'b0001);
        chk("seed_only", 0, int'(if0.locked), 0);

        // Randomized traffic: mostly correct steps, occasional corruption/gaps/clears.
        cp0 = 0; cp1 = 0;
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 19) == 0);
            r0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(4'b0001 << cp0);
            r1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(4'b0001 << cp1);
            if (e) begin
                cp0 = ($urandom_range(0, 15) == 0) ? cp0 : (cp0 + W - 1) % W;
                cp1 = ($urandom_range(0, 15) == 0) ? cp1 : (cp1 + 1) % W;
            end
            drive("rand", r0, r1, e, c);
        end

        // Saturation: 257 errors on the DIR=0 instance.
        drive("clr0", 4'b0000, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 257; i++) begin
            both("sat", 4'b0001);
            both("sat", 4'b1000);
            both("sat", 4'b0100);
            both("sat", 4'b0100);
        end
        chk("sat_255", 0, int'(if0.err_cnt), 255);
        drive("clr_alone", 4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("clr_alone_0", 0, int'(if0.err_cnt), 0);
        both("clr_err", 4'b0001);
        both("clr_err", 4'b1000);
        both("clr_err", 4'b0100);
        drive("clr_err", 4'b0100, 4'b0100, 1'b1, 1'b1);
        chk("clr_err_1", 0, int'(if0.err_cnt), 1);
        both("tail", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
